// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and sizing for the data-memory arbiter
package dmem_pkg;

    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_ADDR_W = 64;
    localparam int DMEM_DEPTH  = 1024;

    localparam logic [1:0] MEM_ST  = 2'b00;
    localparam logic [1:0] MEM_LD  = 2'b01;
    localparam logic [1:0] MEM_NOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LWAIT  = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    function automatic logic addr_oob(input logic [DMEM_ADDR_W-1:0] addr, input int depth);
        return addr >= DMEM_ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester's load/store request and response channel
interface dmem_arbiter_if #(
    parameter int DATA_W = dmem_pkg::DMEM_DATA_W,
    parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-input round-robin grant with pointer register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer favours the requester that lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[0];
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester load/store sequencer for the data memory
// Optional DMEM_ARB_BOUNDS_EN: suppress and flag accesses with addr >= DEPTH.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     req0,
    dmem_arbiter_if.slave     req1,
    output logic [1:0]        mem_control,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datIn,
    input  logic [DATA_W-1:0] mem_datOut
);
    arb_state_t        state;
    logic [1:0]        grant;
    logic              accept;
    logic              sel_we;
    logic              sel_oob;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              lat_we;
    logic              lat_owner;
    logic              lat_err;
    logic [1:0]        rsp_valid_r;
    logic [1:0]        rsp_err_r;
    logic [DATA_W-1:0] rsp_rdata_r [2];

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1.req_valid, req0.req_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign accept         = (state == IDLE) && (grant != 2'b00) && !rst;
    assign req0.req_ready = accept && grant[0];
    assign req1.req_ready = accept && grant[1];

    always_comb begin
        sel_we    = grant[1] ? req1.req_we    : req0.req_we;
        sel_addr  = grant[1] ? req1.req_addr  : req0.req_addr;
        sel_wdata = grant[1] ? req1.req_wdata : req0.req_wdata;
`ifdef DMEM_ARB_BOUNDS_EN
        sel_oob   = addr_oob(sel_addr, DEPTH);
`else
        sel_oob   = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mem_control    <= MEM_NOP;
            mem_addr       <= '0;
            mem_datIn      <= '0;
            lat_we         <= 1'b0;
            lat_owner      <= 1'b0;
            lat_err        <= 1'b0;
            rsp_valid_r    <= 2'b00;
            rsp_err_r      <= 2'b00;
            rsp_rdata_r[0] <= '0;
            rsp_rdata_r[1] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we      <= sel_we;
                        lat_owner   <= grant[1];
                        lat_err     <= sel_oob;
                        mem_addr    <= sel_addr;
                        mem_datIn   <= sel_wdata;
                        mem_control <= sel_oob ? MEM_NOP : (sel_we ? MEM_ST : MEM_LD);
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_control <= MEM_NOP;
                    if (lat_we) begin
                        rsp_valid_r[lat_owner] <= 1'b1;
                        rsp_err_r[lat_owner]   <= lat_err;
                        state                  <= RESP;
                    end else begin
                        state <= LWAIT;
                    end
                end
                LWAIT: begin
                    // mem_datOut is valid here, one cycle after the load control.
                    rsp_valid_r[lat_owner] <= 1'b1;
                    rsp_err_r[lat_owner]   <= lat_err;
                    rsp_rdata_r[lat_owner] <= lat_err ? '0 : mem_datOut;
                    state                  <= RESP;
                end
                RESP: begin
                    rsp_valid_r    <= 2'b00;
                    rsp_err_r      <= 2'b00;
                    rsp_rdata_r[0] <= '0;
                    rsp_rdata_r[1] <= '0;
                    state          <= IDLE;
                end
                default: begin
                    mem_control <= MEM_NOP;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign req0.rsp_valid = rsp_valid_r[0];
    assign req0.rsp_rdata = rsp_rdata_r[0];
    assign req0.rsp_err   = rsp_err_r[0];
    assign req1.rsp_valid = rsp_valid_r[1];
    assign req1.rsp_rdata = rsp_rdata_r[1];
    assign req1.rsp_err   = rsp_err_r[1];
endmodule
